// File: rtl/sa_pkg.sv
// Shared types and sizing for the systolic-array slice: array dimension,
// accumulator width, and the result-drain state encoding.
package sa_pkg;

   localparam int SA_N     = 8;
   localparam int SA_ACC_W = 32;

   typedef enum logic [1:0] {
      DR_IDLE,
      DR_CAPTURE,
      DR_DRAIN
   } drain_state_t;

   typedef logic [SA_ACC_W-1:0] acc_t;

endpackage

// File: rtl/drain_row_buf.sv
// One row of the result buffer: fills its N slots in arrival order while
// capture is enabled and flags any valid that arrives once the row is full.
module drain_row_buf #(
   parameter int N  = 8,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            cap_en,
   input  logic            vld,
   input  logic [DW-1:0]   din,
   output logic [N*DW-1:0] row_data,
   output logic            full,
   output logic            ovf_hit
);

   localparam int CW = $clog2(N+1);
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt;
   logic [DW-1:0] mem [0:N-1];
   logic          wr_en;

   assign full    = (cnt == CW'(N));
   assign wr_en   = cap_en & vld & ~full;
   assign ovf_hit = cap_en & vld & full;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (wr_en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Storage is deliberately left out of reset; only the fill count is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[cnt[AW-1:0]] <= din;
      end
   end

   always_comb begin
      row_data = '0;
      for (int c = 0; c < N; c++) begin
         row_data[c*DW +: DW] = mem[c];
      end
   end

endmodule

// File: rtl/result_drain.sv
// De-skews the systolic array's result stream into an N x N buffer and then
// streams it out one row per beat on a valid/ready handshake.
module result_drain
   import sa_pkg::*;
#(
   parameter int N  = SA_N,
   parameter int DW = SA_ACC_W
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   input  logic [DW-1:0]           RES_IN [0:N-1],
   input  logic [N-1:0]            RES_VLD,
   output logic [DW-1:0]           OUT_DATA [0:N-1],
   output logic [$clog2(N)-1:0]    OUT_ROW,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic                    OUT_LAST,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    OVF
);

   localparam int RW = $clog2(N);

   // Handshake: a beat transfers on any edge where OUT_VALID && OUT_READY;
   // OUT_VALID is a pure function of state, and data/row hold while stalled.

   drain_state_t    state;
   drain_state_t    state_nxt;
   logic [RW-1:0]   rd_row;
   logic [N-1:0]    full_vec;
   logic [N-1:0]    ovf_vec;
   logic [N*DW-1:0] rows [0:N-1];
   logic            start_acc;
   logic            cap_en;
   logic            hs;
   logic            last_row;

   assign start_acc = (state == DR_IDLE) & START;
   assign cap_en    = (state == DR_CAPTURE);
   assign hs        = (state == DR_DRAIN) & OUT_READY;
   assign last_row  = (rd_row == RW'(N-1));

   for (genvar r = 0; r < N; r++) begin : g_row
      drain_row_buf #(
         .N  (N),
         .DW (DW)
      ) u_row (
         .clk      (CLK),
         .rst      (RST),
         .clr      (start_acc),
         .cap_en   (cap_en),
         .vld      (RES_VLD[r]),
         .din      (RES_IN[r]),
         .row_data (rows[r]),
         .full     (full_vec[r]),
         .ovf_hit  (ovf_vec[r])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= DR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Transition out of CAPTURE looks at registered counts, so it trails the
   // final element write by one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         DR_IDLE:    if (START) state_nxt = DR_CAPTURE;
         DR_CAPTURE: if (&full_vec) state_nxt = DR_DRAIN;
         DR_DRAIN:   if (OUT_READY && last_row) state_nxt = DR_IDLE;
         default:    state_nxt = DR_IDLE;
      endcase
   end

   always_comb begin
      OUT_VALID = 1'b0;
      OUT_LAST  = 1'b0;
      BUSY      = 1'b0;
      OUT_ROW   = '0;
      for (int c = 0; c < N; c++) begin
         OUT_DATA[c] = '0;
      end
      case (state)
         DR_CAPTURE: BUSY = 1'b1;
         DR_DRAIN: begin
            BUSY      = 1'b1;
            OUT_VALID = 1'b1;
            OUT_ROW   = rd_row;
            OUT_LAST  = last_row;
            for (int c = 0; c < N; c++) begin
               OUT_DATA[c] = rows[rd_row][c*DW +: DW];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_row <= '0;
         DONE   <= 1'b0;
         OVF    <= 1'b0;
      end else begin
         DONE <= hs & last_row;
         if (hs) begin
            rd_row <= last_row ? '0 : rd_row + 1'b1;
         end
         if (start_acc) begin
            OVF <= 1'b0;
         end else if (|ovf_vec) begin
            OVF <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: skewed fills, drains with and without
// backpressure, overflow, ignored inputs, mid-drain reset and back-to-back runs.
module tb_result_drain;

   localparam int N  = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] res_in [0:N-1];
   logic [N-1:0]  res_vld;
   logic [DW-1:0] out_data [0:N-1];
   logic [2:0]    out_row;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          ovf;

   logic [DW-1:0] exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;

   typedef struct {
      bit ready;
      bit exp_valid;
      int exp_row;
      bit exp_last;
      bit exp_done;
   } bp_vec_t;

   bp_vec_t bp_tab [0:23];

   result_drain dut (
      .CLK       (clk),
      .RST       (rst),
      .START     (start),
      .RES_IN    (res_in),
      .RES_VLD   (res_vld),
      .OUT_DATA  (out_data),
      .OUT_ROW   (out_row),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_LAST  (out_last),
      .BUSY      (busy),
      .DONE      (done),
      .OVF       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] val(input int kind, input int r, input int c);
      if (kind == 0) return DW'(100*r + c);
      return DW'(1000 + 8*r + c);
   endfunction

   // START, then nominal skewed fill (row r column c at t0+r+c); ends in DRAIN
   task automatic fill(input int kind, input int ovf_row, input bit start_mid);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ovf_clr", ovf, 0);
      for (int t = 0; t < 2*N-1; t++) begin
         res_vld = '0;
         for (int r = 0; r < N; r++) begin
            int c = t - r;
            res_in[r] = 32'hBAD0_0000;
            if (c >= 0 && c < N) begin
               res_vld[r] = 1'b1;
               res_in[r]  = val(kind, r, c);
            end else if (r == ovf_row && c == N) begin
               res_vld[r] = 1'b1;
               res_in[r]  = 32'h0000_DEAD;
            end
         end
         start = (start_mid && t == 5);
         tick();
      end
      res_vld = '0;
      start   = 1'b0;
      chk("capture_hold_valid", out_valid, 0);
      chk("capture_hold_busy", busy, 1);
      tick();
      chk("drain_entry_valid", out_valid, 1);
      chk("drain_entry_row", out_row, 0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_q.push_back(val(kind, r, c));
   endtask

   task automatic check_row(input int row);
      chk("beat_valid", out_valid, 1);
      chk("beat_row", out_row, row);
      chk("beat_last", out_last, row == N-1);
      for (int c = 0; c < N; c++) begin
         chk("beat_data", out_data[c], exp_q.pop_front());
      end
   endtask

   // Ready held high: N consecutive beats, returns in the DONE cycle
   task automatic drain_full();
      out_ready = 1'b1;
      for (int row = 0; row < N; row++) begin
         check_row(row);
         tick();
      end
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("post_valid", out_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_row", out_row, 0);
      chk("post_data_zero", out_data[0], 0);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 22; i++) begin
         bp_tab[i].ready     = (i % 3 == 0);
         bp_tab[i].exp_valid = 1'b1;
         bp_tab[i].exp_row   = (i + 2) / 3;
         bp_tab[i].exp_last  = ((i + 2) / 3 == N-1);
         bp_tab[i].exp_done  = 1'b0;
      end
      bp_tab[22] = '{ready: 1'b0, exp_valid: 1'b0, exp_row: 0, exp_last: 1'b0, exp_done: 1'b1};
      bp_tab[23] = '{ready: 1'b0, exp_valid: 1'b0, exp_row: 0, exp_last: 1'b0, exp_done: 1'b0};

      rst       = 1'b1;
      start     = 1'b0;
      res_vld   = '0;
      out_ready = 1'b0;
      for (int r = 0; r < N; r++) res_in[r] = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_last", out_last, 0);
      chk("rst_row", out_row, 0);

      // 1: nominal skew, ready always high
      fill(0, -1, 1'b0);
      drain_full();
      tick();
      chk("done_single_cycle", done, 0);

      // 2: backpressure, ready 1,0,0,...
      fill(0, -1, 1'b0);
      for (int i = 0; i < 24; i++) begin
         out_ready = bp_tab[i].ready;
         chk("bp_valid", out_valid, bp_tab[i].exp_valid);
         chk("bp_row", out_row, bp_tab[i].exp_row);
         chk("bp_last", out_last, bp_tab[i].exp_last);
         chk("bp_done", done, bp_tab[i].exp_done);
         if (bp_tab[i].exp_valid) begin
            for (int c = 0; c < N; c++) chk("bp_data", out_data[c], exp_q[c]);
            if (bp_tab[i].ready)
               for (int c = 0; c < N; c++) void'(exp_q.pop_front());
         end
         tick();
      end
      out_ready = 1'b0;
      chk("bp_queue_empty", exp_q.size(), 0);

      // 3: overflow on row 3 (ninth value 0xDEAD)
      fill(0, 3, 1'b0);
      chk("ovf_set", ovf, 1);
      drain_full();
      chk("ovf_sticky", ovf, 1);

      // 4: ignored inputs in IDLE, START during CAPTURE, inputs during DRAIN
      res_vld = '1;
      for (int r = 0; r < N; r++) res_in[r] = 32'h5555_0000 + DW'(r);
      tick();
      tick();
      res_vld = '0;
      chk("idle_vld_busy", busy, 0);
      chk("idle_vld_valid", out_valid, 0);
      chk("idle_vld_ovf", ovf, 1);
      fill(0, -1, 1'b1);
      res_vld = '1;
      start   = 1'b1;
      tick();
      tick();
      res_vld = '0;
      start   = 1'b0;
      chk("drain_ign_row", out_row, 0);
      chk("drain_ign_busy", busy, 1);
      chk("drain_ign_ovf", ovf, 0);
      drain_full();
      tick();

      // 5: reset at drain beat 4, then fresh fill with new data
      fill(0, -1, 1'b0);
      out_ready = 1'b1;
      for (int row = 0; row < 4; row++) begin
         check_row(row);
         tick();
      end
      rst       = 1'b1;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_row", out_row, 0);
      chk("abort_done", done, 0);
      exp_q.delete();
      fill(1, -1, 1'b0);
      drain_full();
      tick();

      // 6: back-to-back, START in the DONE cycle
      fill(0, -1, 1'b0);
      drain_full();
      fill(1, -1, 1'b0);
      drain_full();
      tick();
      chk("b2b_done_clear", done, 0);
      chk("b2b_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Output-side counterpart of the operand register file. It collects the skewed result stream leaving the systolic array and de-skews it into an N x N result buffer.
- It then streams the buffer to the host side one row per beat over a valid/ready handshake.
- Sits between the PE array's result outputs and the host/AXI read path; it closes the load -> compute -> drain loop.

Parameters:
- N, 8, array dimension (rows = columns = N).
- DW, 32, result element width (accumulator width).
- CW, $clog2(N+1), per-row column counter width (derived; do not override).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle pulse; arms capture. Honoured only in IDLE.
- RES_IN  in  [DW-1:0] x N  result element per array row, unpacked array [0:N-1].
- RES_VLD  in  N  per-row valid; bit r qualifies RES_IN[r].
- OUT_DATA  out  [DW-1:0] x N  one full result row, unpacked array [0:N-1].
- OUT_ROW  out  $clog2(N)  index of the row on OUT_DATA.
- OUT_VALID  out  1  OUT_DATA/OUT_ROW valid.
- OUT_READY  in  1  downstream accept.
- OUT_LAST  out  1  high with OUT_VALID when OUT_ROW == N-1.
- BUSY  out  1  high in CAPTURE or DRAIN.
- DONE  out  1  one-cycle pulse after the last row handshake.
- OVF  out  1  sticky error: valid seen on a row already holding N elements; cleared by START or RST.

Behaviour:
- Reset (RST=1 at an edge): state IDLE; all column counters 0; read row 0; OUT_VALID, OUT_LAST, BUSY, DONE, OVF = 0.
  - OUT_DATA and OUT_ROW read 0 whenever OUT_VALID=0.
  - Buffer contents are not cleared.
  - RST asserted mid-CAPTURE or mid-DRAIN aborts immediately, with the same values.
- States are IDLE, CAPTURE and DRAIN.
- IDLE:
  - RES_VLD is ignored.
  - START=1 -> CAPTURE next cycle; column counters cleared, OVF cleared.
- CAPTURE:
  - Per row r, each cycle with RES_VLD[r]=1 and cnt[r]<N: buf[r][cnt[r]] <= RES_IN[r], cnt[r] <= cnt[r]+1.
  - Rows are independent. Arbitrary per-row skew and gaps are tolerated; nominal timing is row r column c at t0+r+c.
  - RES_VLD[r]=1 with cnt[r]==N: data dropped, OVF <= 1.
  - When all cnt[r]==N at a clock edge -> DRAIN next cycle. The final element's write and the transition decision use registered counts, so DRAIN is entered exactly 1 cycle after the last capture edge.
  - START in CAPTURE is ignored.
- DRAIN:
  - OUT_VALID=1; OUT_DATA[c] = buf[rd_row][c]; OUT_ROW = rd_row.
  - OUT_DATA and OUT_ROW are held stable while OUT_VALID && !OUT_READY.
  - Handshake (OUT_VALID && OUT_READY) with rd_row<N-1: rd_row++.
  - Handshake with rd_row==N-1: -> IDLE, rd_row <= 0, DONE=1 for exactly the next cycle, OUT_VALID drops that same cycle.
  - RES_VLD and START are ignored in DRAIN.
- OUT_VALID never depends combinationally on OUT_READY.
- Minimum drain time is N cycles with OUT_READY held high.
- START coinciding with DONE (both in the IDLE-entry cycle) is accepted: the START edge sees IDLE, so CAPTURE begins next cycle.
- No arithmetic is performed. Data passes bit-exact, with no width change.

Decomposition:
- Shared package sa_pkg holds:
  - constants SA_N=8 and SA_ACC_W=32;
  - typedef enum logic [1:0] {DR_IDLE, DR_CAPTURE, DR_DRAIN} drain_state_t;
  - typedef logic [SA_ACC_W-1:0] acc_t.
- One sub-module, drain_row_buf, instantiated N times. Each instance is one row: N x DW registers, a CW-bit counter, a full flag and an overflow-hit output. The top holds only the FSM, rd_row and the output mux.

Test Plan:
1. Nominal skew: START, then rows fed with buf[r][c] = 100*r + c at t0+r+c, OUT_READY=1.
   - Required: DRAIN 1 cycle after the row-7 column-7 capture (t0+14).
   - Required: 8 consecutive beats; row r carries {100r .. 100r+7}; OUT_LAST only on beat 8; DONE pulse 1 cycle later.
2. Backpressure: same fill, OUT_READY toggles 1,0,0,1,...
   - Required: OUT_DATA and OUT_ROW stable across stalls; all 8 rows delivered in order; no duplicates.
3. Overflow: row 3 receives 9 valids (9th value 0xDEAD).
   - Required: OVF=1 and sticky; row 3 drains as its first 8 values only. The next START clears OVF.
4. Ignored inputs: RES_VLD pulses in IDLE and during DRAIN, START during CAPTURE.
   - Required: no state or buffer change, counters unaffected.
5. Reset mid-operation: RST at drain beat 4.
   - Required: next cycle OUT_VALID=0, BUSY=0, OUT_ROW=0, DONE=0.
   - Required: a fresh START plus fill with new data (1000+8r+c) drains the new values correctly.
6. Back-to-back: START asserted in the cycle DONE is high.
   - Required: BUSY high the next cycle and a second capture/drain completes with correct data.
